// File: rtl/reg_bank_arb_pkg.sv
// Shared definitions for the register-bank load arbiter and the register bank:
// bank opcodes, arbiter state encodings and small helpers.
package reg_bank_arb_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LD0 = 4'h1,
        OP_LD1 = 4'h2,
        OP_LD2 = 4'h3,
        OP_LD3 = 4'h4,
        OP_LD4 = 4'h5,
        OP_LD5 = 4'h6,
        OP_LD6 = 4'h7,
        OP_LD7 = 4'h8
    } opcode_e;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_READY = 2'd1,
        ST_ISSUE = 2'd3,
        ST_ERROR = 2'd2
    } state_e;

    localparam int unsigned NREQ = 4;

    // Register k is loaded by opcode LDk, encoded as k+1 so that 0 stays NOP.
    function automatic logic [3:0] ld_opcode(input logic [2:0] reg_idx);
        return {1'b0, reg_idx} + 4'd1;
    endfunction

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/reg_bank_arb_rr_pick4.sv
// Combinational 4-way picker: first asserted request at or after start, ascending mod 4.
module rr_pick4 (
    input  logic [3:0] req_i,
    input  logic [1:0] start_i,
    output logic [3:0] grant_o,
    output logic       valid_o
);

    always_comb begin
        logic [1:0] idx;
        idx     = 2'd0;
        grant_o = 4'b0000;
        valid_o = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start_i + 2'(i);
            if (!valid_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bank_arb.sv
// Four-requester load arbiter feeding an 8x8 register bank (one load per two cycles).
// Define REG_BANK_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module reg_bank_arb
    import reg_bank_arb_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [11:0] ld_reg,
    input  logic [31:0] ld_val,
    output logic [3:0]  ack,
    output logic [11:0] inst,
    output logic        inst_en,
    output logic        busy,
    output logic        error
);

    state_e      state_q, state_d;
    logic [3:0]  pending_q, pending_d;
    logic [3:0]  ack_q, ack_d;
    logic [11:0] inst_q, inst_d;
    logic        inst_en_q, inst_en_d;
    logic [3:0]  grant;
    logic        grant_vld;
    logic [1:0]  start;
    logic [2:0]  win_reg;
    logic [7:0]  win_val;
    logic        withdraw;

`ifdef REG_BANK_ARB_FIXED_PRIO_EN
    assign start = 2'd0;
`else
    logic [1:0] ptr_q, ptr_d;
    assign start = ptr_q;
`endif

    rr_pick4 u_pick (
        .req_i   (req),
        .start_i (start),
        .grant_o (grant),
        .valid_o (grant_vld)
    );

    // A requester that was seen but not yet served must keep its request up.
    assign withdraw = |(pending_q & ~req);

    always_comb begin
        win_reg = 3'd0;
        win_val = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (grant[i]) begin
                win_reg = ld_reg[3*i +: 3];
                win_val = ld_val[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        inst_d    = {OP_NOP, 8'h00};
        inst_en_d = 1'b0;
        ack_d     = 4'b0000;
`ifndef REG_BANK_ARB_FIXED_PRIO_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            ST_RESET: state_d = ST_READY;
            ST_READY: begin
                if (withdraw) begin
                    state_d = ST_ERROR;
                end else if (grant_vld) begin
                    state_d   = ST_ISSUE;
                    inst_d    = {ld_opcode(win_reg), win_val};
                    inst_en_d = 1'b1;
                    ack_d     = grant;
                    pending_d = (pending_q | req) & ~grant;
`ifndef REG_BANK_ARB_FIXED_PRIO_EN
                    ptr_d     = oh2idx(grant) + 2'd1;
`endif
                end
            end
            ST_ISSUE: state_d = withdraw ? ST_ERROR : ST_READY;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_RESET;
            pending_q <= 4'b0000;
            ack_q     <= 4'b0000;
            inst_q    <= 12'h000;
            inst_en_q <= 1'b0;
`ifndef REG_BANK_ARB_FIXED_PRIO_EN
            ptr_q     <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            inst_q    <= inst_d;
            inst_en_q <= inst_en_d;
`ifndef REG_BANK_ARB_FIXED_PRIO_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign ack     = ack_q;
    assign inst    = inst_q;
    assign inst_en = inst_en_q;
    assign busy    = (state_q == ST_ISSUE);
    assign error   = (state_q == ST_ERROR);

endmodule

// File: tb/tb_reg_bank_arb.sv
// Self-checking bench for reg_bank_arb: vector table plus scoreboard of expected issues.
module tb_reg_bank_arb;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] ld_reg;
    logic [31:0] ld_val;
    logic [3:0]  ack;
    logic [11:0] inst;
    logic        inst_en;
    logic        busy;
    logic        error;

    reg_bank_arb dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .ld_reg  (ld_reg),
        .ld_val  (ld_val),
        .ack     (ack),
        .inst    (inst),
        .inst_en (inst_en),
        .busy    (busy),
        .error   (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  ack;
        logic [11:0] inst;
    } exp_t;

    typedef struct {
        int          idx;
        logic [2:0]  rg;
        logic [7:0]  val;
        logic [11:0] exp_inst;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       vecs[6];
    int         n_chk  = 0;
    int         n_fail = 0;
    logic       prev_en = 1'b0;
    logic [3:0] rearm  = 4'b0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // One cycle: sample at negedge, score outputs, model requesters dropping on ack.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        if (inst_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_inst_en", 32'(inst_en), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("inst", 32'(inst), 32'(e.inst));
                check("ack", 32'(ack), 32'(e.ack));
                check("busy_in_issue", 32'(busy), 32'd1);
            end
            check("no_back_to_back", 32'(prev_en), 32'd0);
        end else begin
            check("inst_idle_zero", 32'(inst), 32'd0);
            check("ack_idle_zero", 32'(ack), 32'd0);
        end
        prev_en = (inst_en === 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (ack[i] === 1'b1 && !rearm[i]) req[i] = 1'b0;
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] rg, input logic [7:0] val);
        ld_reg[3*i +: 3] = rg;
        ld_val[8*i +: 8] = val;
        req[i] = 1'b1;
    endtask

    task automatic push(input logic [3:0] a, input logic [11:0] ins);
        exp_t e;
        e.ack  = a;
        e.inst = ins;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget, output int cyc);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            tick();
            cyc++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        rearm = 4'b0000;
        tick();
        tick();
        check("rst_inst", 32'(inst), 32'd0);
        check("rst_inst_en", 32'(inst_en), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        int cyc;
        reset  = 1'b1;
        req    = 4'b0000;
        ld_reg = 12'h000;
        ld_val = 32'h0;

        vecs[0] = '{0, 3'd3, 8'hA5, 12'h4A5};
        vecs[1] = '{1, 3'd0, 8'h00, 12'h100};
        vecs[2] = '{2, 3'd7, 8'hFF, 12'h8FF};
        vecs[3] = '{3, 3'd5, 8'h3C, 12'h63C};
        vecs[4] = '{1, 3'd1, 8'h5A, 12'h25A};
        vecs[5] = '{0, 3'd7, 8'h01, 12'h801};

        // Reset state, then first load two cycles after release.
        do_reset();
        set_req(0, 3'd3, 8'hA5);
        push(4'b0001, 12'h4A5);
        wait_drain(10, cyc);
        check("first_latency", 32'(cyc), 32'd2);

        // Single-requester loads from the table.
        foreach (vecs[k]) begin
            set_req(vecs[k].idx, vecs[k].rg, vecs[k].val);
            push(4'(1 << vecs[k].idx), vecs[k].exp_inst);
            wait_drain(10, cyc);
        end
        check("no_error_after_table", 32'(error), 32'd0);

        // All four requesting: served 0,1,2,3, never back to back.
        do_reset();
        set_req(0, 3'd0, 8'h10);
        set_req(1, 3'd1, 8'h21);
        set_req(2, 3'd2, 8'h32);
        set_req(3, 3'd3, 8'h43);
        push(4'b0001, 12'h110);
        push(4'b0010, 12'h221);
        push(4'b0100, 12'h332);
        push(4'b1000, 12'h443);
        wait_drain(20, cyc);
        repeat (3) tick();
        check("all4_error", 32'(error), 32'd0);

        // Arbitration policy: after serving 1, requesters 0 and 3 compete.
        do_reset();
        set_req(1, 3'd4, 8'h99);
        push(4'b0010, 12'h599);
        wait_drain(10, cyc);
        set_req(0, 3'd2, 8'hC0);
        set_req(3, 3'd6, 8'hC3);
`ifdef REG_BANK_ARB_FIXED_PRIO_EN
        push(4'b0001, 12'h3C0);
        push(4'b1000, 12'h7C3);
`else
        push(4'b1000, 12'h7C3);
        push(4'b0001, 12'h3C0);
`endif
        wait_drain(20, cyc);

`ifdef REG_BANK_ARB_FIXED_PRIO_EN
        // Requester 0 keeps re-requesting and starves the others without error.
        do_reset();
        rearm = 4'b0001;
        set_req(0, 3'd1, 8'hE0);
        set_req(1, 3'd1, 8'hE1);
        set_req(2, 3'd1, 8'hE2);
        set_req(3, 3'd1, 8'hE3);
        for (int k = 0; k < 4; k++) begin
            push(4'b0001, 12'h2E0);
            wait_drain(10, cyc);
        end
        check("starve_no_error", 32'(error), 32'd0);
        reset = 1'b1;
        req   = 4'b0000;
        rearm = 4'b0000;
        tick();
`endif

        // Pending requester withdraws while another holds the grant.
        do_reset();
        set_req(0, 3'd2, 8'h11);
        set_req(1, 3'd3, 8'h22);
        push(4'b0001, 12'h311);
        wait_drain(10, cyc);
        req[1] = 1'b0;
        tick();
        check("withdraw_error", 32'(error), 32'd1);
        check("withdraw_busy", 32'(busy), 32'd0);
        req = 4'b1111;
        repeat (5) tick();
        check("error_sticky", 32'(error), 32'd1);
        check("error_inst_en", 32'(inst_en), 32'd0);
        do_reset();
        check("error_cleared", 32'(error), 32'd0);

        // Reset during an Issue cycle cancels it; next grant two cycles after release.
        set_req(2, 3'd6, 8'h77);
        push(4'b0100, 12'h777);
        wait_drain(10, cyc);
        reset = 1'b1;
        tick();
        check("cancel_inst_en", 32'(inst_en), 32'd0);
        check("cancel_ack", 32'(ack), 32'd0);
        check("cancel_inst", 32'(inst), 32'd0);
        tick();
        reset = 1'b0;
        set_req(2, 3'd6, 8'h78);
        push(4'b0100, 12'h778);
        wait_drain(10, cyc);
        check("regrant_latency", 32'(cyc), 32'd2);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
